// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA sync/colour monitor: line/frame timing and per-frame active-picture CRC
// CRC logic is present only when VGA_MON_CRC_EN is defined; otherwise frame_crc is tied to 0.
module vga_frame_monitor #(
  parameter int CW       = 3,
  parameter int SYNC_POL = 0,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk_vga,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          vga_hsync,
  input  logic          vga_vsync,
  input  logic [CW-1:0] vga_r,
  input  logic [CW-1:0] vga_g,
  input  logic [CW-1:0] vga_b,
  output logic [10:0]   line_len,
  output logic [9:0]    frame_lines,
  output logic [15:0]   frame_crc,
  output logic [15:0]   frame_count,
  output logic          frame_done,
  output logic          locked,
  output logic          err_line
);

  localparam logic SPOL = SYNC_POL[0];

  typedef enum logic {SEEK, LOCK} state_t;
  state_t state, state_nx;

  logic        s_hs, s_vs, p_hs, p_vs;
  logic        hs_edge, vs_edge, frame_end, skip_chk;
  logic [10:0] hcount, len_nx;
  logic [9:0]  vcount;

  assign hs_edge = (s_hs == SPOL) && (p_hs != SPOL);
  assign vs_edge = (s_vs == SPOL) && (p_vs != SPOL);
  assign len_nx  = (hcount == 11'h7FF) ? 11'h7FF : hcount + 11'd1;
  assign locked  = (state == LOCK);

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) state <= SEEK;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    case (state)
      SEEK: if (vs_edge) state_nx = LOCK;
      LOCK: frame_end = vs_edge;
      default: state_nx = SEEK;
    endcase
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      s_hs        <= ~SPOL;
      s_vs        <= ~SPOL;
      p_hs        <= ~SPOL;
      p_vs        <= ~SPOL;
      hcount      <= '0;
      vcount      <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      skip_chk    <= 1'b1;
    end else begin
      s_hs <= vga_hsync;
      s_vs <= vga_vsync;
      p_hs <= s_hs;
      p_vs <= s_vs;

      if (hs_edge) begin
        hcount   <= '0;
        line_len <= len_nx;
      end else if (hcount != 11'h7FF) begin
        hcount <= hcount + 11'd1;
      end

      if (vs_edge)      vcount <= '0;
      else if (hs_edge) vcount <= vcount + 10'd1;

      frame_done <= frame_end;
      if (frame_end) frame_lines <= vcount + {9'd0, hs_edge};

      if (clear)          frame_count <= '0;
      else if (frame_end) frame_count <= frame_count + 16'd1;

      // The line after a vsync edge may be partial, so its length is never compared.
      if (vs_edge)      skip_chk <= 1'b1;
      else if (hs_edge) skip_chk <= 1'b0;

      if (clear)
        err_line <= 1'b0;
      else if (locked && hs_edge && !skip_chk && (len_nx != line_len))
        err_line <= 1'b1;
    end
  end

`ifdef VGA_MON_CRC_EN
  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

  logic [3*CW-1:0] s_rgb;
  logic [15:0]     crc;
  logic            pix_active;

  assign pix_active = ({1'b0, hcount} >= H_LO) && ({1'b0, hcount} < H_HI) &&
                      ({1'b0, vcount} >= V_LO) && ({1'b0, vcount} < V_HI);

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [3*CW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 3*CW-1; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      s_rgb     <= '0;
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      s_rgb <= {vga_r, vga_g, vga_b};
      if (frame_end) begin
        frame_crc <= crc;
        crc       <= 16'hFFFF;
      end else if (locked && pix_active) begin
        crc <= crc_step(crc, s_rgb);
      end
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - scoreboard bench for vga_frame_monitor on a reduced 40x30 raster
module tb_vga_frame_monitor;

  localparam int CW = 3, HT = 40, HS_W = 4, VT = 30, VS_W = 2;
  localparam int HSTART = 8, HACT = 24, VSTART = 4, VACT = 20;
`ifdef VGA_MON_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clear, hs, vs;
  logic [CW-1:0] r, g, b;
  logic [10:0] line_len_lo, line_len_hi;
  logic [9:0]  frame_lines_lo, frame_lines_hi;
  logic [15:0] frame_crc_lo, frame_crc_hi, frame_count_lo, frame_count_hi;
  logic        done_lo, done_hi, locked_lo, locked_hi, err_lo, err_hi;

  vga_frame_monitor #(.CW(CW), .SYNC_POL(0), .H_START(HSTART), .H_ACTIVE(HACT),
                      .V_START(VSTART), .V_ACTIVE(VACT)) dut_lo (
    .clk_vga(clk), .reset_n(reset_n), .clear(clear), .vga_hsync(hs), .vga_vsync(vs),
    .vga_r(r), .vga_g(g), .vga_b(b), .line_len(line_len_lo), .frame_lines(frame_lines_lo),
    .frame_crc(frame_crc_lo), .frame_count(frame_count_lo), .frame_done(done_lo),
    .locked(locked_lo), .err_line(err_lo));

  vga_frame_monitor #(.CW(CW), .SYNC_POL(1), .H_START(HSTART), .H_ACTIVE(HACT),
                      .V_START(VSTART), .V_ACTIVE(VACT)) dut_hi (
    .clk_vga(clk), .reset_n(reset_n), .clear(clear), .vga_hsync(~hs), .vga_vsync(~vs),
    .vga_r(r), .vga_g(g), .vga_b(b), .line_len(line_len_hi), .frame_lines(frame_lines_hi),
    .frame_crc(frame_crc_hi), .frame_count(frame_count_hi), .frame_done(done_hi),
    .locked(locked_hi), .err_line(err_hi));

  typedef struct packed {
    logic [10:0] len;
    logic [9:0]  lines;
    logic [15:0] crc;
    logic [15:0] count;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          tests = 0, fails = 0;
  logic [15:0] m_crc = 16'hFFFF, m_count = '0;
  logic        m_err = 1'b0, m_locked = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [3*CW-1:0] d);
    logic [15:0] x;
    x = c ^ {d, 7'b0};
    for (int i = 0; i < 3*CW; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  // Pin cycle k of a line is seen by the monitor with hcount = k-1.
  function automatic bit is_active(input int l, input int k);
    return (k >= 1) && (k - 1 >= HSTART) && (k - 1 < HSTART + HACT) &&
           (l >= VSTART) && (l < VSTART + VACT);
  endfunction

  task automatic chk_zero(input string who);
    chk({who, "_line_len"}, line_len_lo, 0);
    chk({who, "_frame_lines"}, frame_lines_lo, 0);
    chk({who, "_frame_crc"}, frame_crc_lo, 0);
    chk({who, "_frame_count"}, frame_count_lo, 0);
    chk({who, "_frame_done"}, done_lo, 0);
    chk({who, "_locked"}, locked_lo, 0);
    chk({who, "_err_line"}, err_lo, 0);
    chk({who, "_hi_locked"}, locked_hi, 0);
    chk({who, "_hi_frame_count"}, frame_count_hi, 0);
  endtask

  task automatic check_frame_end(input int l, input int k);
    logic exp_done;
    exp_done = (l == 0) && (k == 1) && (q.size() > 0);
    if (exp_done || done_lo || done_hi) begin
      chk("frame_done_lo", done_lo, exp_done);
      chk("frame_done_hi", done_hi, exp_done);
      if (exp_done) begin
        e = q.pop_front();
        chk("line_len_lo", line_len_lo, e.len);
        chk("frame_lines_lo", frame_lines_lo, e.lines);
        chk("frame_crc_lo", frame_crc_lo, e.crc);
        chk("frame_count_lo", frame_count_lo, e.count);
        chk("err_line_lo", err_lo, e.err);
        chk("locked_lo", locked_lo, 1);
        chk("line_len_hi", line_len_hi, e.len);
        chk("frame_lines_hi", frame_lines_hi, e.lines);
        chk("frame_crc_hi", frame_crc_hi, e.crc);
        chk("frame_count_hi", frame_count_hi, e.count);
      end
    end
  endtask

  task automatic drive_frame(input int mode, input int short_line, input int clear_line,
                             input int rst_line, input int stop_line);
    bit aborted;
    aborted  = 1'b0;
    m_crc    = 16'hFFFF;
    m_locked = 1'b1;
    for (int l = 0; l < VT; l++) begin
      int len;
      if (l == stop_line) return;
      len = (l == short_line) ? HT - 1 : HT;
      for (int k = 0; k < len; k++) begin
        logic [3*CW-1:0] rgb;
        hs = (k < HS_W) ? 1'b0 : 1'b1;
        vs = (l < VS_W) ? 1'b0 : 1'b1;
        case (mode)
          0:       rgb = '0;
          1:       rgb = '1;
          default: rgb = 9'(l * 37 + k * 11);
        endcase
        {r, g, b} = rgb;
        clear = (l == clear_line) && (k == ((l == 0) ? 1 : 5));
        if (clear) begin
          m_count = '0;
          m_err   = 1'b0;
          if (l == 0 && q.size() > 0) begin
            e = q.pop_front();
            e.count = '0;
            e.err   = 1'b0;
            q.push_front(e);
          end
        end
        if (m_locked && is_active(l, k)) m_crc = crc_word(m_crc, rgb);
        @(posedge clk);
        #1;
        check_frame_end(l, k);
        if (clear && l != 0) begin
          chk("clear_frame_count", frame_count_lo, 0);
          chk("clear_err_line", err_lo, 0);
        end
        if (short_line >= 0 && l == short_line + 1 && k == 0)
          chk("err_before_short_edge", err_lo, m_err);
        if (short_line >= 0 && l == short_line + 1 && k == 1) begin
          m_err = 1'b1;
          chk("err_line_lo_short", err_lo, 1);
          chk("err_line_hi_short", err_hi, 1);
          chk("line_len_short", line_len_lo, HT - 1);
        end
        if (l == rst_line && k == 20) begin
          reset_n = 1'b0;
          #1;
          chk_zero("midreset");
          chk("midreset_hi_crc", frame_crc_hi, 0);
          m_locked = 1'b0;
          m_count  = '0;
          m_err    = 1'b0;
          aborted  = 1'b1;
        end
        if (l == rst_line && k == 24) reset_n = 1'b1;
      end
    end
    if (!aborted) begin
      m_count = m_count + 16'd1;
      q.push_back('{len: 11'(HT), lines: 10'(VT), crc: CRC_EN ? m_crc : 16'h0,
                    count: m_count, err: m_err});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    hs      = 1'b1;
    vs      = 1'b1;
    {r, g, b} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    drive_frame(0, -1, -1, -1, -1);
    chk("locked_after_first_vs", locked_lo, 1);
    chk("count_after_first_vs", frame_count_lo, 0);
    drive_frame(0, -1, -1, -1, -1);
    drive_frame(1, -1, -1, -1, -1);
    drive_frame(0, -1, -1, -1, -1);
    drive_frame(2, -1, -1, -1, -1);
    drive_frame(0, 10, -1, -1, -1);
    drive_frame(0, -1, -1, -1, -1);
    drive_frame(0, -1, 5, -1, -1);
    drive_frame(0, -1, 0, -1, -1);
    drive_frame(0, -1, -1, 10, -1);
    chk("locked_after_partial", locked_lo, 0);
    chk("locked_hi_after_partial", locked_hi, 0);
    drive_frame(2, -1, -1, -1, -1);
    drive_frame(0, -1, -1, -1, -1);
    drive_frame(0, -1, -1, -1, 2);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Synthesizable VGA output monitor for the arcade video path: observes the `clk_vga`-domain sync and colour lines driven by the top level, measures line and frame timing, and computes a per-frame CRC over the active picture. It replaces the simulator-only VGA capture with hardware that runs on the board and in any bench, and is parametrised in colour depth, sync polarity and active-window geometry. Results update once per frame, so a bench or debug port can compare frame signatures without a display.

## Interface
- `CW`, 3: bits per colour channel
- `SYNC_POL`, 0: active level of both syncs (0 = active-low)
- `H_START`, 144: `hcount` of the first active pixel
- `H_ACTIVE`, 640: active pixels per line
- `V_START`, 35: `vcount` of the first active line
- `V_ACTIVE`, 480: active lines per frame
- `clk_vga`  in  1  pixel clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous: clears `err_line` and `frame_count`
- `vga_hsync`, `vga_vsync`  in  1  sync inputs
- `vga_r`, `vga_g`, `vga_b`  in  CW  colour inputs
- `line_len`  out  11  clocks per line, from the latest hsync-to-hsync period
- `frame_lines`  out  10  hsync edges in the last complete frame
- `frame_crc`  out  16  CRC of the last complete frame's active pixels
- `frame_count`  out  16  completed frames, wraps
- `frame_done`  out  1  one-cycle pulse when the frame outputs update
- `locked`  out  1  high once the first vsync edge has been seen
- `err_line`  out  1  sticky: line length changed within a frame

## Operation
- Input stage:
  - All inputs are registered once (`s_hs`, `s_vs`, `s_rgb`).
  - A sync is "active" when it equals `SYNC_POL`.
  - Leading edge: active now, inactive in the previous registered sample.
- `hcount` (11 bits):
  - Set to 0 on an hsync edge; otherwise increments and saturates at 2047.
  - On an hsync edge, `line_len <= hcount + 1` (saturating at 2047).
- `vcount` (10 bits):
  - Increments on an hsync edge.
  - On a vsync edge, `vcount <= 0`; vsync takes priority over a coincident hsync edge.
- State machine:
  - SEEK (after reset) → LOCK on the first vsync edge.
  - LOCK has no exit except reset.
  - In SEEK: no CRC accumulation, `frame_done` stays low, `err_line` is not updated.
- Active pixel: `H_START <= hcount < H_START+H_ACTIVE` and `V_START <= vcount < V_START+V_ACTIVE`, evaluated on the registered stage.
- CRC:
  - CRC-16-CCITT, polynomial 0x1021, initial value 0xFFFF.
  - Each active pixel feeds the 3·CW-bit word `{r,g,b}`, MSB first, one full word per clock.
- Frame end (vsync edge while in LOCK):
  - `frame_lines <= vcount + (hsync edge this cycle ? 1 : 0)`
  - `frame_crc <=` running CRC
  - `frame_count++`
  - `frame_done` pulses.
  - Running CRC reinitialises to 0xFFFF in the same cycle.
- `err_line`:
  - Set on an hsync edge in LOCK when the new `line_len` differs from the previous one.
  - Not evaluated on the first hsync edge after a vsync edge.
- `clear`:
  - Zeroes `err_line` and `frame_count`.
  - If it coincides with a frame end, `frame_count` becomes 0 (clear wins).
- Reset:
  - All outputs 0, state SEEK, running CRC 0xFFFF.
  - Reset mid-frame discards the partial frame.

## Timing
- Input-pin-to-edge detection: 1 clock (input register).
- `frame_done` and the frame outputs assert/update on the clock after the registered vsync edge, i.e. 2 clocks after the pin transition.
- `line_len` updates on the same clock as the registered hsync edge.
- The CRC of the last active pixel is included as long as that pixel precedes the vsync edge by ≥1 clock.
- Outputs hold between updates.

## Configuration
- `VGA_MON_CRC_EN`:
  - Defined: CRC logic present as described.
  - Undefined: no CRC logic; `frame_crc` is constant 0. All other outputs behave identically.

## Test plan
- Reset, then 800×525 frames (hsync 96 clocks, vsync 2 lines), all colours 0 → after the 2nd vsync edge: `locked=1`, `frame_done` pulse, `line_len=800`, `frame_lines=525`, `frame_count=1`, `err_line=0`.
- Same timing, one frame with all active pixels `{r,g,b}` = 9'h1FF (CW=3) → `frame_crc` equals the software CRC-16-CCITT of 307200 words of 9'h1FF; the following frame with zeros returns the zero-frame CRC.
- One line shortened to 799 clocks mid-frame → `err_line=1` from that hsync edge and sticky across frames; assert `clear` → `err_line=0`, `frame_count=0`.
- `SYNC_POL=1` instance fed inverted syncs → identical `line_len`, `frame_lines` and CRC to the active-low case.
- Assert `reset_n` low mid-frame → all outputs 0 immediately; on release, `locked` stays 0 until the next vsync edge, and no `frame_done` pulse occurs for the partial frame.
- Compile without `VGA_MON_CRC_EN` → `frame_crc=0` and timing outputs match the first scenario.
